// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the PC generator and its controller.
// The master drives the next-PC controls; the slave (pc_gen) returns PC and RAS status.
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             en;
  logic [1:0]       PCsrc;
  logic             call;
  logic [WIDTH-1:0] ImmOp;
  logic [WIDTH-1:0] RegBase;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC_plus4;
  logic             misaligned;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output en, PCsrc, call, ImmOp, RegBase,
    input  PC, PC_plus4, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  en, PCsrc, call, ImmOp, RegBase,
    output PC, PC_plus4, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential/branch/JALR/return targets with alignment check.
// Define PC_GEN_RAS_EN to build the circular return-address stack.
module pc_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  ifc
);
  logic [WIDTH-1:0] r_pc;
  logic             r_mis;
  logic [WIDTH-1:0] w_plus4;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_jalr;
  logic [WIDTH-1:0] w_target;
  logic             w_aligned;

  assign w_plus4   = r_pc + WIDTH'(4);
  assign w_sum     = ifc.RegBase + ifc.ImmOp;
  assign w_jalr    = {w_sum[WIDTH-1:1], 1'b0};
  assign w_aligned = (w_target[1:0] == 2'b00);

`ifdef PC_GEN_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             w_push;
  logic             w_swap;
  logic             w_pop;
  logic [PW-1:0]    w_top_nxt;
  logic [CW-1:0]    w_count_nxt;

  always_comb begin
    w_target = w_plus4;
    unique case (ifc.PCsrc)
      2'b00: w_target = w_plus4;
      2'b01: w_target = r_pc + ifc.ImmOp;
      2'b10: w_target = w_jalr;
      2'b11: w_target = r_empty ? w_jalr : r_ras[r_top];
    endcase
  end

  // A return with call on a non-empty stack swaps the top entry in place.
  always_comb begin
    w_push = w_aligned && ifc.call &&
             ((ifc.PCsrc == 2'b01) || (ifc.PCsrc == 2'b10) ||
              ((ifc.PCsrc == 2'b11) && r_empty));
    w_swap = w_aligned && ifc.call && (ifc.PCsrc == 2'b11) && !r_empty;
    w_pop  = w_aligned && !ifc.call && (ifc.PCsrc == 2'b11) && !r_empty;
    w_top_nxt   = r_top;
    w_count_nxt = r_count;
    if (w_push) begin
      w_top_nxt   = r_top + PW'(1);
      w_count_nxt = r_full ? r_count : r_count + CW'(1);
    end else if (w_pop) begin
      w_top_nxt   = r_top - PW'(1);
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ifc.en && (w_push || w_swap))
      r_ras[w_top_nxt] <= w_plus4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else if (ifc.en) begin
      r_top   <= w_top_nxt;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH_C);
    end
  end

  assign ifc.ras_empty = r_empty;
  assign ifc.ras_full  = r_full;
`else
  logic w_unused;

  always_comb begin
    w_target = w_plus4;
    unique case (ifc.PCsrc)
      2'b00: w_target = w_plus4;
      2'b01: w_target = r_pc + ifc.ImmOp;
      2'b10: w_target = w_jalr;
      2'b11: w_target = w_jalr;
    endcase
  end

  assign w_unused      = ^{ifc.call, RAS_DEPTH[0]};
  assign ifc.ras_empty = 1'b1;
  assign ifc.ras_full  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RESET_PC;
      r_mis <= 1'b0;
    end else if (ifc.en) begin
      r_mis <= !w_aligned;
      if (w_aligned)
        r_pc <= w_target;
    end
  end

  assign ifc.PC         = r_pc;
  assign ifc.PC_plus4   = w_plus4;
  assign ifc.misaligned = r_mis;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: queue-based reference model compared every cycle,
// plus literal expectations along the way. Honours PC_GEN_RAS_EN like the design.
module tb_pc_gen;
  localparam int unsigned W     = 32;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam int unsigned DEPTH = 4;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pc_gen_if #(.WIDTH(W)) bus ();

  pc_gen #(.WIDTH(W), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .ifc (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural PC, misaligned flag, RAS as a bounded queue.
  logic [31:0] m_pc  = RST_PC;
  bit          m_mis = 1'b0;
  logic [31:0] m_ras [$];

  task automatic model_step();
    logic [31:0] t;
    logic [31:0] link;
    link = m_pc + 32'd4;
    case (bus.PCsrc)
      2'd0: t = m_pc + 32'd4;
      2'd1: t = m_pc + bus.ImmOp;
      2'd2: t = (bus.RegBase + bus.ImmOp) & 32'hFFFF_FFFE;
      default: t = (RAS_ON && m_ras.size() > 0) ? m_ras[$]
                                                : ((bus.RegBase + bus.ImmOp) & 32'hFFFF_FFFE);
    endcase
    if (t % 4 != 0) begin
      m_mis = 1'b1;
    end else begin
      m_mis = 1'b0;
      m_pc  = t;
      if (RAS_ON) begin
        if (bus.PCsrc == 2'd3 && m_ras.size() > 0) begin
          if (bus.call) m_ras[m_ras.size()-1] = link;
          else          void'(m_ras.pop_back());
        end else if (bus.call && bus.PCsrc != 2'd0) begin
          m_ras.push_back(link);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc  = RST_PC;
      m_mis = 1'b0;
      m_ras.delete();
    end else if (bus.en) begin
      model_step();
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.PC !== m_pc || bus.PC_plus4 !== m_pc + 32'd4 ||
        bus.misaligned !== m_mis ||
        bus.ras_empty !== (m_ras.size() == 0) ||
        bus.ras_full !== (m_ras.size() == DEPTH)) begin
      failures++;
      $display("FAIL model t=%0t: PC=%h p4=%h mis=%b e=%b f=%b, required PC=%h p4=%h mis=%b e=%b f=%b",
               $time, bus.PC, bus.PC_plus4, bus.misaligned, bus.ras_empty, bus.ras_full,
               m_pc, m_pc + 32'd4, m_mis, m_ras.size() == 0, m_ras.size() == DEPTH);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic step(input bit e, input logic [1:0] src, input bit c,
                      input logic [31:0] imm, input logic [31:0] rb);
    bus.en      = e;
    bus.PCsrc   = src;
    bus.call    = c;
    bus.ImmOp   = imm;
    bus.RegBase = rb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b0;
    bus.en = 1'b0; bus.PCsrc = 2'd0; bus.call = 1'b0;
    bus.ImmOp = '0; bus.RegBase = '0;
    #12;
    chk("reset_pc", bus.PC, RST_PC);
    chk("reset_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("reset_full", {31'd0, bus.ras_full}, 32'd0);
    chk("reset_mis", {31'd0, bus.misaligned}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("hold_before_en", bus.PC, 32'h0);

    step(1, 2'd0, 0, 0, 0); chk("inc1", bus.PC, 32'h4);
    step(1, 2'd0, 0, 0, 0); chk("inc2", bus.PC, 32'h8);
    step(1, 2'd0, 0, 0, 0); chk("inc3", bus.PC, 32'hC);
    chk("inc3_plus4", bus.PC_plus4, 32'h10);

    step(1, 2'd2, 0, 32'h0, 32'h100);        chk("jalr_100", bus.PC, 32'h100);
    step(1, 2'd1, 0, 32'hFFFF_FFF0, 32'h0);  chk("branch_back", bus.PC, 32'hF0);
    step(1, 2'd2, 0, 32'h0, 32'h201);        chk("jalr_bit0", bus.PC, 32'h200);

    step(1, 2'd2, 0, 32'h0, 32'h40);         chk("jalr_40", bus.PC, 32'h40);
    step(1, 2'd1, 1, 32'h2, 32'h0);
    chk("mis_hold", bus.PC, 32'h40);
    chk("mis_pulse", {31'd0, bus.misaligned}, 32'd1);
    chk("mis_no_push", {31'd0, bus.ras_empty}, 32'd1);
    step(1, 2'd0, 0, 0, 0);
    chk("mis_clear", {31'd0, bus.misaligned}, 32'd0);
    chk("after_mis", bus.PC, 32'h44);
    step(1, 2'd2, 0, 32'h0, 32'h42);
    chk("mis_jalr_hold", bus.PC, 32'h44);
    chk("mis_jalr_pulse", {31'd0, bus.misaligned}, 32'd1);

    step(1, 2'd2, 0, 32'h0, 32'hFFFF_FFFC);
    chk("top_addr", bus.PC, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.PC_plus4, 32'h0);
    step(1, 2'd0, 0, 0, 0);                  chk("wrap_inc", bus.PC, 32'h0);

`ifdef PC_GEN_RAS_EN
    step(1, 2'd2, 0, 32'h0, 32'h10);
    for (int i = 2; i <= 6; i++) begin
      step(1, 2'd2, 1, 32'h0, 32'(i * 16));
      chk("call_target", bus.PC, 32'(i * 16));
    end
    chk("ras_full", {31'd0, bus.ras_full}, 32'd1);
    step(1, 2'd3, 0, 0, 0); chk("ret1", bus.PC, 32'h54);
    chk("ras_not_full", {31'd0, bus.ras_full}, 32'd0);
    step(1, 2'd3, 0, 0, 0); chk("ret2", bus.PC, 32'h44);
    step(1, 2'd3, 0, 0, 0); chk("ret3", bus.PC, 32'h34);
    step(1, 2'd3, 0, 0, 0); chk("ret4", bus.PC, 32'h24);
    chk("ras_empty_after", {31'd0, bus.ras_empty}, 32'd1);
    step(1, 2'd3, 0, 32'h0, 32'h80); chk("ret_fallback", bus.PC, 32'h80);
    step(1, 2'd2, 1, 32'h0, 32'h90); chk("call_90", bus.PC, 32'h90);
    step(1, 2'd3, 1, 0, 0);          chk("swap_ret", bus.PC, 32'h84);
    chk("swap_keeps", {31'd0, bus.ras_empty}, 32'd0);
    step(1, 2'd3, 0, 0, 0);          chk("ret_swapped", bus.PC, 32'h94);
    chk("swap_popped", {31'd0, bus.ras_empty}, 32'd1);
    step(1, 2'd2, 1, 32'h0, 32'hA0); chk("call_a0", bus.PC, 32'hA0);
`else
    step(1, 2'd3, 1, 32'h0, 32'h300);
    chk("ret_as_jalr", bus.PC, 32'h300);
    chk("no_ras_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("no_ras_full", {31'd0, bus.ras_full}, 32'd0);
`endif

    held = bus.PC;
    for (int i = 0; i < 5; i++) begin
      step(0, 2'(i), 1'(i), 32'(i * 8 + 4), 32'(i * 32 + 16));
      chk("stall_pc", bus.PC, held);
      chk("stall_empty", {31'd0, bus.ras_empty}, {31'd0, !RAS_ON});
    end
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pc", bus.PC, RST_PC);
    chk("async_rst_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("async_rst_mis", {31'd0, bus.misaligned}, 32'd0);
    @(negedge clk) rst = 1'b1;
    step(1, 2'd0, 0, 0, 0);
    chk("post_rst_inc", bus.PC, RST_PC + 32'd4);
    step(1, 2'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
